// File: rtl/segment_value_sampler_pkg.sv
// Shared constants for the segment value sampler: FSM encoding, segment kinds
// and the LFSR feedback polynomial.
package segment_value_sampler_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_DRAW  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] SEG_NONE   = 2'd0;
    localparam logic [1:0] SEG_KIND_1 = 2'd1;
    localparam logic [1:0] SEG_KIND_2 = 2'd2;
    localparam logic [1:0] SEG_KIND_3 = 2'd3;

    localparam logic [15:0] LFSR_MASK_16 = 16'hB400;

endpackage

// File: rtl/segment_value_sampler_lfsr_galois.sv
// Right-shifting Galois LFSR with synchronous load and advance enable.
// A zero seed would lock the register, so it is replaced by 1.
module lfsr_galois
    import segment_value_sampler_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OUT_WIDTH = 8,
    parameter logic [WIDTH-1:0] FEEDBACK = WIDTH'(LFSR_MASK_16)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     seed,
    output logic [OUT_WIDTH-1:0] out_bits
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (seed == '0) ? WIDTH'(1) : seed;
        end else if (enable) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? FEEDBACK : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WIDTH'(1);
        end else begin
            state_q <= state_d;
        end
    end

    assign out_bits = state_q[OUT_WIDTH-1:0];

endmodule

// File: rtl/segment_value_sampler.sv
// Draws a uniform integer in [from, to] of the chosen segment using LFSR
// rejection sampling, with a deterministic fold-back after MAX_RETRIES draws.
module segment_value_sampler
    import segment_value_sampler_pkg::*;
#(
    parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE   = 8,
    parameter int MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = 2,
    parameter int LFSR_WIDTH                          = 16,
    parameter int MAX_RETRIES                         = 4
) (
    input  logic                                           in_clk,
    input  logic                                           in_reset,
    input  logic                                           in_seed_load,
    input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE:0]     in_seed,
    input  logic                                           in_start,
    input  logic [1:0]                                     in_segment_type,
    input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]   in_segment_from,
    input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]   in_segment_to,
    input  logic [MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX-1:0] in_variable_index,
    output logic                                           out_busy,
    output logic                                           out_valid,
    output logic                                           out_error,
    output logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0]   out_proposed_value,
    output logic [MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX-1:0] out_variable_index,
    output logic [1:0]                                     out_debug_state
);

    localparam int W  = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
    localparam int XW = W + 1;
    localparam int IW = MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX;
    localparam int RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;

    logic [1:0]    state_q, state_d;
    logic [1:0]    type_q, type_d;
    logic [W-1:0]  from_q, from_d;
    logic [W-1:0]  to_q, to_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          err_q, err_d;
    logic [W-1:0]  value_q, value_d;
    logic          out_valid_q, out_valid_d;
    logic          out_error_q, out_error_d;
    logic [W-1:0]  out_value_q, out_value_d;
    logic [IW-1:0] out_index_q, out_index_d;

    logic [W-1:0]  lfsr_bits;
    logic [XW-1:0] from_x;
    logic [XW-1:0] span;
    logic [XW-1:0] mask;
    logic [XW-1:0] cand;
    logic          accept;

    lfsr_galois #(
        .WIDTH    (LFSR_WIDTH),
        .OUT_WIDTH(W)
    ) u_lfsr (
        .clk     (in_clk),
        .rst_n   (in_reset),
        .load    (in_seed_load && (state_q == ST_IDLE)),
        .enable  (state_q == ST_DRAW),
        .seed    (LFSR_WIDTH'(in_seed)),
        .out_bits(lfsr_bits)
    );

    // span is W+1 bits signed; its MSB is the "to < from" flag. The mask is the
    // span with every bit below its leading one filled in.
    always_comb begin
        from_x = {from_q[W-1], from_q};
        span   = {to_q[W-1], to_q} - from_x;
        mask   = span;
        for (int i = 1; i < XW; i = i * 2) begin
            mask = mask | (mask >> i);
        end
        cand   = {1'b0, lfsr_bits} & mask;
        accept = (cand <= span);
    end

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        from_d      = from_q;
        to_d        = to_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        err_d       = err_q;
        value_d     = value_q;
        out_valid_d = 1'b0;
        out_error_d = 1'b0;
        out_value_d = out_value_q;
        out_index_d = out_index_q;
        case (state_q)
            ST_IDLE: begin
                if (in_start) begin
                    type_d  = in_segment_type;
                    from_d  = in_segment_from;
                    to_d    = in_segment_to;
                    idx_d   = in_variable_index;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((type_q == SEG_NONE) || span[W]) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    err_d   = 1'b0;
                    retry_d = '0;
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (accept) begin
                    value_d = W'(from_x + cand);
                    state_d = ST_DONE;
                end else if (retry_q == RW'(MAX_RETRIES - 1)) begin
                    // mask < 2*(span+1), so cand-span-1 still lands inside the range
                    value_d = W'(from_x + (cand - span - XW'(1)));
                    state_d = ST_DONE;
                end else begin
                    retry_d = retry_q + RW'(1);
                end
            end
            ST_DONE: begin
                out_valid_d = 1'b1;
                out_error_d = err_q;
                out_index_d = idx_q;
                if (!err_q) begin
                    out_value_d = value_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q     <= ST_IDLE;
            type_q      <= '0;
            from_q      <= '0;
            to_q        <= '0;
            idx_q       <= '0;
            retry_q     <= '0;
            err_q       <= 1'b0;
            value_q     <= '0;
            out_valid_q <= 1'b0;
            out_error_q <= 1'b0;
            out_value_q <= '0;
            out_index_q <= '0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            from_q      <= from_d;
            to_q        <= to_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            err_q       <= err_d;
            value_q     <= value_d;
            out_valid_q <= out_valid_d;
            out_error_q <= out_error_d;
            out_value_q <= out_value_d;
            out_index_q <= out_index_d;
        end
    end

    assign out_busy           = (state_q != ST_IDLE);
    assign out_valid          = out_valid_q;
    assign out_error          = out_error_q;
    assign out_proposed_value = out_value_q;
    assign out_variable_index = out_index_q;
    assign out_debug_state    = state_q;

endmodule

// File: tb/tb_segment_value_sampler.sv
// Directed plus randomized bench for segment_value_sampler against a
// draw-by-draw arithmetic model of the sampling rules.
module tb_segment_value_sampler;

    localparam int MAX_RETRIES = 4;
    localparam int TIMEOUT     = 20;

    logic       in_clk;
    logic       in_reset;
    logic       in_seed_load;
    logic [8:0] in_seed;
    logic       in_start;
    logic [1:0] in_segment_type;
    logic [7:0] in_segment_from;
    logic [7:0] in_segment_to;
    logic [1:0] in_variable_index;
    logic       out_busy;
    logic       out_valid;
    logic       out_error;
    logic [7:0] out_proposed_value;
    logic [1:0] out_variable_index;
    logic [1:0] out_debug_state;

    segment_value_sampler dut (
        .in_clk            (in_clk),
        .in_reset          (in_reset),
        .in_seed_load      (in_seed_load),
        .in_seed           (in_seed),
        .in_start          (in_start),
        .in_segment_type   (in_segment_type),
        .in_segment_from   (in_segment_from),
        .in_segment_to     (in_segment_to),
        .in_variable_index (in_variable_index),
        .out_busy          (out_busy),
        .out_valid         (out_valid),
        .out_error         (out_error),
        .out_proposed_value(out_proposed_value),
        .out_variable_index(out_variable_index),
        .out_debug_state   (out_debug_state)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_st;
    int m_last_val;
    bit e_err;
    int e_val;
    int e_lat;
    int e_idx;
    int elapsed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lfsr_next(input int s);
        int v;
        v = s & 32'hFFFF;
        return (v & 1) ? ((v >> 1) ^ 32'hB400) : (v >> 1);
    endfunction

    // Rejection sampling expressed with plain integers over the bounds.
    function automatic void predict(input int st, input int ty, input int lo, input int hi,
                                    output bit err, output int val, output int draws,
                                    output int st_out);
        int span;
        int mask;
        int cand;
        span  = hi - lo;
        err   = 1'b0;
        val   = 0;
        draws = 0;
        st_out = st;
        if (ty == 0 || span < 0) begin
            err = 1'b1;
            return;
        end
        mask = 0;
        while (mask < span) mask = mask * 2 + 1;
        for (int r = 0; r < MAX_RETRIES; r++) begin
            cand   = st_out & mask;
            st_out = lfsr_next(st_out);
            draws++;
            if (cand <= span) begin
                val = lo + cand;
                return;
            end
            if (r == MAX_RETRIES - 1) val = lo + (cand - span - 1);
        end
    endfunction

    task automatic seed_load(input int s);
        @(negedge in_clk);
        in_seed_load = 1'b1;
        in_seed      = 9'(s);
        @(negedge in_clk);
        in_seed_load = 1'b0;
        m_st = ((s & 511) == 0) ? 1 : (s & 511);
    endtask

    task automatic start_req(input int ty, input int lo, input int hi, input int idx);
        bit err;
        int val;
        int draws;
        int st_out;
        predict(m_st, ty, lo, hi, err, val, draws, st_out);
        e_err = err;
        e_lat = err ? 2 : draws + 2;
        e_val = err ? m_last_val : val;
        e_idx = idx;
        m_st  = st_out;
        if (!err) m_last_val = val;
        @(negedge in_clk);
        in_start          = 1'b1;
        in_segment_type   = 2'(ty);
        in_segment_from   = 8'(lo);
        in_segment_to     = 8'(hi);
        in_variable_index = 2'(idx);
        @(negedge in_clk);
        in_start = 1'b0;
        elapsed  = 0;
        check("busy_after_start", 32'(out_busy), 32'd1);
    endtask

    task automatic wait_result(input string tag);
        bit got;
        got = 1'b0;
        while (!got && elapsed < TIMEOUT) begin
            @(negedge in_clk);
            elapsed++;
            if (out_valid) got = 1'b1;
        end
        check({tag, "_latency"}, 32'(elapsed), 32'(e_lat));
        if (got) begin
            check({tag, "_error"}, 32'(out_error), 32'(e_err));
            check({tag, "_value"}, 32'(out_proposed_value), 32'(e_val & 255));
            check({tag, "_index"}, 32'(out_variable_index), 32'(e_idx));
            check({tag, "_busy_at_valid"}, 32'(out_busy), 32'd0);
            @(negedge in_clk);
            check({tag, "_valid_pulse"}, 32'(out_valid), 32'd0);
        end
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge in_clk);
            if (out_valid) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    task automatic do_reset();
        in_reset = 1'b0;
        repeat (2) @(negedge in_clk);
        in_reset   = 1'b1;
        m_st       = 1;
        m_last_val = 0;
    endtask

    initial begin
        int fold_seed;
        int st;
        bit ok;
        int lo;
        int hi;

        in_reset          = 1'b0;
        in_seed_load      = 1'b0;
        in_seed           = '0;
        in_start          = 1'b0;
        in_segment_type   = '0;
        in_segment_from   = '0;
        in_segment_to     = '0;
        in_variable_index = '0;
        m_st              = 1;
        m_last_val        = 0;

        #12;
        check("reset_busy", 32'(out_busy), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_error", 32'(out_error), 32'd0);
        check("reset_value", 32'(out_proposed_value), 32'd0);
        check("reset_index", 32'(out_variable_index), 32'd0);
        do_reset();

        start_req(3, -3, -3, 2);
        wait_result("single_point");

        do_reset();
        seed_load(1);
        start_req(3, -128, 127, 1);
        wait_result("full_range");
        check("full_range_value_direct", 32'(out_proposed_value), 32'(8'h81));

        start_req(0, 10, 20, 3);
        wait_result("type_none");

        start_req(1, 5, 2, 0);
        wait_result("inverted_bounds");

        // Seed whose first MAX_RETRIES states all give cand in 5..7 for mask 7.
        fold_seed = 0;
        for (int s = 1; s < 512 && fold_seed == 0; s++) begin
            st = s;
            ok = 1'b1;
            for (int r = 0; r < MAX_RETRIES; r++) begin
                if ((st & 7) < 5) ok = 1'b0;
                st = lfsr_next(st);
            end
            if (ok) fold_seed = s;
        end
        check("fold_seed_found", 32'(fold_seed != 0), 32'd1);

        seed_load(fold_seed);
        start_req(2, 0, 4, 1);
        wait_result("fold_back");
        check("fold_back_latency_direct", 32'(elapsed), 32'(2 + MAX_RETRIES));

        // Second start and a seed load while drawing must both be ignored.
        seed_load(fold_seed);
        start_req(2, 0, 4, 1);
        repeat (2) begin
            @(negedge in_clk);
            elapsed++;
        end
        in_start          = 1'b1;
        in_seed_load      = 1'b1;
        in_seed           = 9'h155;
        in_segment_type   = 2'd1;
        in_segment_from   = 8'(-50);
        in_segment_to     = 8'd50;
        in_variable_index = 2'd2;
        @(negedge in_clk);
        elapsed++;
        in_start     = 1'b0;
        in_seed_load = 1'b0;
        wait_result("ignored_second_start");
        expect_quiet("no_ghost_result", 8);

        // Asynchronous reset in the middle of the draw loop.
        seed_load(fold_seed);
        start_req(2, 0, 4, 3);
        repeat (2) @(negedge in_clk);
        #1;
        in_reset = 1'b0;
        #1;
        check("midreset_busy", 32'(out_busy), 32'd0);
        check("midreset_valid", 32'(out_valid), 32'd0);
        check("midreset_value", 32'(out_proposed_value), 32'd0);
        check("midreset_index", 32'(out_variable_index), 32'd0);
        @(negedge in_clk);
        in_reset   = 1'b1;
        m_st       = 1;
        m_last_val = 0;
        expect_quiet("midreset_no_valid", 8);
        start_req(1, 10, 20, 2);
        wait_result("after_midreset");

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) seed_load(int'($urandom_range(0, 511)));
            lo = int'($urandom_range(0, 255)) - 128;
            if ($urandom_range(0, 3) == 0) begin
                hi = lo + int'($urandom_range(0, 5));
                if (hi > 127) hi = 127;
            end else begin
                hi = int'($urandom_range(0, 255)) - 128;
            end
            start_req(int'($urandom_range(0, 3)), lo, hi, int'($urandom_range(0, 3)));
            wait_result("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
